// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - three-port arbiter/sequencer in front of a word-based PSRAM controller
//
// Purpose:
//   Shares one PSRAM controller between video fetch (port 0), CPU (port 1)
//   and loader/DMA (port 2). One request is latched at a time. It is issued
//   as a one-cycle read/write pulse, the controller busy handshake is tracked,
//   and a per-port ack is returned. Port 0 has priority. A starvation counter
//   forces a port 1/2 grant after STARVE_LIMIT back-to-back port-0 grants.
//   A watchdog aborts with err if busy never rises or never falls.
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   req[2:0], we[2:0], bw[2:0]     per-port request level, write enable, byte write
//   addr0..2 [21:0], din0..2 [15:0] per-port byte address and write data
//   ack[2:0], err                  one-cycle completion pulse / watchdog abort flag
//   dout[15:0]                     read data, valid on the ack cycle of a read
//   grant_id[1:0]                  port owning the controller, 3 = none
//   mem_read, mem_write            one-cycle command pulse to the controller
//   mem_addr, mem_din, mem_byte_write  latched command fields
//   mem_dout, mem_busy             controller read data and busy

module psram_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 64,
    parameter int START_WAIT   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [21:0] addr0,
    input  logic [21:0] addr1,
    input  logic [21:0] addr2,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    input  logic [15:0] din2,
    input  logic [2:0]  bw,
    output logic [2:0]  ack,
    output logic [15:0] dout,
    output logic        err,
    output logic [1:0]  grant_id,
    output logic        mem_read,
    output logic        mem_write,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_byte_write,
    input  logic [15:0] mem_dout,
    input  logic        mem_busy
);

    localparam int CNT_MAX  = (TIMEOUT > START_WAIT) ? TIMEOUT : START_WAIT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [1:0]         rr_q, rr_d;
    logic [1:0]         grant_q, grant_d;
    logic               is_write_q, is_write_d;
    logic [2:0]         ack_q, ack_d;
    logic               err_q, err_d;
    logic [15:0]        dout_q, dout_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [21:0]        mem_addr_q, mem_addr_d;
    logic [15:0]        mem_din_q, mem_din_d;
    logic               mem_bw_q, mem_bw_d;

    logic               low_req;
    logic               force_low;
    logic [1:0]         win;

    // Winner selection for the current IDLE cycle.
    always_comb begin
        low_req   = |req[2:1];
        force_low = low_req && (starve_q == STARVE_W'(STARVE_LIMIT));
        if (req[0] && !force_low) begin
            win = 2'd0;
        end else if (rr_q == 2'd1) begin
            win = req[1] ? 2'd1 : 2'd2;
        end else begin
            win = req[2] ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        is_write_d  = is_write_q;
        ack_d       = 3'b000;
        err_d       = 1'b0;
        dout_d      = dout_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_bw_d    = mem_bw_q;
        starve_d    = low_req ? starve_q : '0;

        case (state_q)
            IDLE: begin
                // ack_q blocks the ack cycle so a requester still holding
                // req there is not re-served before it can drop it.
                if (!mem_busy && (|req) && (ack_q == 3'b000)) begin
                    grant_d     = win;
                    is_write_d  = we[win];
                    mem_bw_d    = bw[win];
                    // Pulse is registered so it is visible during ISSUE.
                    mem_write_d = we[win];
                    mem_read_d  = ~we[win];
                    case (win)
                        2'd0: begin
                            mem_addr_d = addr0;
                            mem_din_d  = din0;
                        end
                        2'd1: begin
                            mem_addr_d = addr1;
                            mem_din_d  = din1;
                        end
                        default: begin
                            mem_addr_d = addr2;
                            mem_din_d  = din2;
                        end
                    endcase
                    if (win == 2'd0) begin
                        starve_d = low_req ? starve_q + 1'b1 : '0;
                    end else begin
                        starve_d = '0;
                        rr_d     = (win == 2'd1) ? 2'd2 : 2'd1;
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end

            WAIT_START: begin
                if (mem_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_WAIT - 1)) begin
                    ack_d   = 3'b001 << grant_q;
                    err_d   = 1'b1;
                    grant_d = 2'd3;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_DONE: begin
                if (!mem_busy) begin
                    ack_d   = 3'b001 << grant_q;
                    if (!is_write_q) begin
                        dout_d = mem_dout;
                    end
                    grant_d = 2'd3;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ack_d   = 3'b001 << grant_q;
                    err_d   = 1'b1;
                    grant_d = 2'd3;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 2'd3;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            rr_q        <= 2'd1;
            grant_q     <= 2'd3;
            is_write_q  <= 1'b0;
            ack_q       <= 3'b000;
            err_q       <= 1'b0;
            dout_q      <= 16'h0000;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 22'h0;
            mem_din_q   <= 16'h0000;
            mem_bw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            is_write_q  <= is_write_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dout_q      <= dout_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_bw_q    <= mem_bw_d;
        end
    end

    assign ack            = ack_q;
    assign err            = err_q;
    assign dout           = dout_q;
    assign grant_id       = grant_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign mem_byte_write = mem_bw_q;

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Three-port arbiter/sequencer that shares the single word-based PSRAM controller between requesters: video fetch (port 0), CPU (port 1) and loader/DMA (port 2).
- Sits between the requesters and the PSRAM controller's read/write/addr/din/byte_write/dout/busy interface.
- Latches one request at a time, issues a one-cycle command pulse, tracks controller busy, and returns a per-port ack with read data.
- Includes starvation protection and a completion watchdog.

Parameters:
- STARVE_LIMIT, 8: consecutive port-0 grants allowed while port 1 or 2 is pending before a forced low-priority grant.
- TIMEOUT, 64: cycles to wait for the controller's busy to fall before aborting with an error.
- START_WAIT, 4: cycles to wait for busy to rise after issue before aborting.

Ports:
- clk  in  1  system clock, same clock as the PSRAM controller
- resetn  in  1  asynchronous, active-low reset
- req  in  3  per-port request level; held high until the matching ack
- we  in  3  per-port write enable (1 = write, 0 = read)
- addr0/addr1/addr2  in  22 each  byte address
- din0/din1/din2  in  16 each  write data
- bw  in  3  per-port byte write; addr[0] selects the upper byte
- ack  out  3  one-cycle completion pulse per port
- dout  out  16  read data, valid on the ack cycle of a read
- err  out  1  one-cycle pulse on watchdog abort, coincident with ack
- grant_id  out  2  port currently owning the controller; 3 = none
- mem_read, mem_write  out  1 each  command pulse to the controller
- mem_addr  out  22  latched address
- mem_din  out  16  latched write data
- mem_byte_write  out  1  latched byte write
- mem_dout  in  16  controller read data
- mem_busy  in  1  controller busy

Behaviour:
- Reset (async, resetn=0) forces:
  - state=IDLE; ack=0, err=0, mem_read=0, mem_write=0.
  - mem_addr=0, mem_din=0, mem_byte_write=0, dout=0.
  - grant_id=3, rr_ptr=1, starve_cnt=0.
  - A transaction in flight when reset asserts is dropped; no ack is issued for it.
- States: IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> IDLE.
- IDLE: if mem_busy=0 and any req bit is set, pick a winner and latch its we, addr, din and bw into the mem_* registers; grant_id=winner; go to ISSUE.
- Arbitration:
  - Port 0 wins unless starve_cnt == STARVE_LIMIT.
  - Otherwise ports 1/2 are served round-robin starting from rr_ptr.
  - rr_ptr toggles to the other low port after each port 1/2 grant.
  - starve_cnt increments on each port-0 grant made while req[1] or req[2] is high.
  - starve_cnt clears on any port 1/2 grant, or when req[2:1]=0.
  - With starve_cnt at the limit and req[2:1]=0, port 0 wins normally.
- ISSUE (exactly 1 cycle): mem_write=latched we, mem_read=~latched we; go to WAIT_START with counter=0.
- WAIT_START:
  - mem_read/mem_write are 0.
  - When mem_busy=1, go to WAIT_DONE with counter=0.
  - If the counter reaches START_WAIT, abort.
- WAIT_DONE:
  - When mem_busy=0, complete: ack[grant_id]=1 for one cycle. For a read, dout<=mem_dout on that same cycle. For a write, dout is unchanged. Then return to IDLE.
  - If the counter reaches TIMEOUT, abort.
- Abort: ack[grant_id]=1 and err=1 for one cycle; dout unchanged; return to IDLE.
- Latency:
  - Grant occurs in the IDLE cycle that sees req.
  - Command pulse follows 1 cycle after grant.
  - ack occurs 1 cycle after the controller's busy falls.
  - No new command is issued until the cycle after ack, giving at least 1 idle cycle between transactions.
- The requester drops req on the cycle after ack. A req still high in the cycle after ack is treated as a new request.
- req changes while the request is granted are ignored because all request fields are latched.
- Simultaneous requests: exactly one grant per IDLE cycle; losers wait with no ack.
- grant_id holds its value through WAIT_DONE and returns to 3 in IDLE.

Test Plan:
- Single read, port 1, addr=0x000010; model busy high 12 cycles with mem_dout=0xBEEF -> exactly one mem_read pulse with mem_addr=0x000010; ack[1] 1 cycle after busy falls; dout=0xBEEF; err=0.
- Byte write, port 2: addr=0x000003, din=0x5A00, bw=1 -> mem_write pulse with mem_byte_write=1, mem_din=0x5A00; ack[2] after busy falls; dout unchanged.
- Ports 0, 1 and 2 all held high, STARVE_LIMIT=8 -> grant order 0×8, 1, 0×8, 2, 0×8, 1.
- Ports 1 and 2 only, continuously requesting -> strict alternation 1, 2, 1, 2.
- Busy never rises after issue -> ack and err pulse together START_WAIT cycles later; next request is served normally.
- Busy stuck high -> ack and err after TIMEOUT cycles.
- resetn pulsed low during WAIT_DONE -> all outputs take reset values immediately; no ack is produced for the dropped transaction.
